// File: rtl/crc_framer.sv
`default_nettype none
// ============================================================================
//  Module      : crc_framer
//  Description : Serialises a 1..4 byte payload LSB first towards an external
//                CRC LFSR stage, then collects the 8 returned CRC bits into a
//                byte with a bounded wait for each bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_framer #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IN_DATA,
  input  logic [1:0]  IN_LEN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        SER_DATA,
  output logic        SER_ACTIVE,
  input  logic        CRC_BIT,
  input  logic        CRC_VALID,
  output logic [7:0]  OUT_CRC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        ERR
);

  localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [31:0]         r_shreg,     w_shreg_nxt;
  logic [5:0]          r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0]          r_cap,       w_cap_nxt;
  logic [3:0]          r_cap_cnt,   w_cap_cnt_nxt;
  logic [c_WAIT_W-1:0] r_wait,      w_wait_nxt;
  logic                r_in_ready,  w_in_ready_nxt;
  logic                r_ser_data,  w_ser_data_nxt;
  logic                r_ser_act,   w_ser_act_nxt;
  logic [7:0]          r_out_crc,   w_out_crc_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_err,       w_err_nxt;

  logic [2:0]          w_len_p1;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic [7:0]          w_cap_shift;

  // Payload length in bytes, the bit count it implies, and the helpers below.
  assign w_len_p1    = {1'b0, IN_LEN} + 3'd1;
  assign w_wait_inc  = r_wait + c_WAIT_W'(1);
  assign w_cap_shift = {CRC_BIT, r_cap[7:1]};

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_cap_nxt       = r_cap;
    w_cap_cnt_nxt   = r_cap_cnt;
    w_wait_nxt      = r_wait;
    w_in_ready_nxt  = r_in_ready;
    w_ser_data_nxt  = r_ser_data;
    w_ser_act_nxt   = r_ser_act;
    w_out_crc_nxt   = r_out_crc;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (IN_VALID && r_in_ready) begin
          // Bit 0 goes out immediately, the rest waits in the shift register.
          w_shreg_nxt    = {1'b0, IN_DATA[31:1]};
          w_ser_data_nxt = IN_DATA[0];
          w_ser_act_nxt  = 1'b1;
          w_bit_cnt_nxt  = {w_len_p1, 3'b000};
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = SHIFT;
        end
      end

      SHIFT: begin
        if (r_bit_cnt == 6'd1) begin
          // Last bit has been on the line for its cycle; start collecting CRC.
          w_ser_data_nxt = 1'b0;
          w_ser_act_nxt  = 1'b0;
          w_bit_cnt_nxt  = 6'd0;
          w_shreg_nxt    = 32'd0;
          w_cap_nxt      = 8'd0;
          w_cap_cnt_nxt  = 4'd0;
          w_wait_nxt     = '0;
          w_state_nxt    = CAPTURE;
        end else begin
          w_ser_data_nxt = r_shreg[0];
          w_shreg_nxt    = {1'b0, r_shreg[31:1]};
          w_bit_cnt_nxt  = r_bit_cnt - 6'd1;
        end
      end

      CAPTURE: begin
        if (CRC_VALID) begin
          // Bits enter at the MSB so the first one ends up at OUT_CRC[0].
          w_wait_nxt = '0;
          if (r_cap_cnt == 4'd7) begin
            w_out_crc_nxt   = w_cap_shift;
            w_out_valid_nxt = 1'b1;
            w_cap_nxt       = 8'd0;
            w_cap_cnt_nxt   = 4'd0;
            w_state_nxt     = RESULT;
          end else begin
            w_cap_nxt     = w_cap_shift;
            w_cap_cnt_nxt = r_cap_cnt + 4'd1;
          end
        end else if (w_wait_inc == c_WAIT_W'(TIMEOUT)) begin
          // LFSR stage went quiet for too long: drop the partial byte.
          w_err_nxt      = 1'b1;
          w_in_ready_nxt = 1'b1;
          w_cap_nxt      = 8'd0;
          w_cap_cnt_nxt  = 4'd0;
          w_wait_nxt     = '0;
          w_state_nxt    = IDLE;
        end else begin
          w_wait_nxt = w_wait_inc;
        end
      end

      RESULT: begin
        if (OUT_READY) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_shreg     <= 32'd0;
      r_bit_cnt   <= 6'd0;
      r_cap       <= 8'd0;
      r_cap_cnt   <= 4'd0;
      r_wait      <= '0;
      r_in_ready  <= 1'b1;
      r_ser_data  <= 1'b0;
      r_ser_act   <= 1'b0;
      r_out_crc   <= 8'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_cap       <= w_cap_nxt;
      r_cap_cnt   <= w_cap_cnt_nxt;
      r_wait      <= w_wait_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_ser_data  <= w_ser_data_nxt;
      r_ser_act   <= w_ser_act_nxt;
      r_out_crc   <= w_out_crc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign IN_READY   = r_in_ready;
  assign SER_DATA   = r_ser_data;
  assign SER_ACTIVE = r_ser_act;
  assign OUT_CRC    = r_out_crc;
  assign OUT_VALID  = r_out_valid;
  assign ERR        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_crc_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_crc_framer
//  Description : Directed self-checking bench for crc_framer with a
//                scoreboard of expected serial bits and CRC bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_framer;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IN_DATA = 32'd0;
  logic [1:0]  IN_LEN = 2'd0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        SER_DATA;
  logic        SER_ACTIVE;
  logic        CRC_BIT = 1'b0;
  logic        CRC_VALID = 1'b0;
  logic [7:0]  OUT_CRC;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic        ERR;

  int n_assert = 0;
  int n_fail   = 0;

  logic       q_bits[$];
  logic [7:0] q_crc[$];

  always #5 CLK = ~CLK;

  crc_framer #(.TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_DATA    (IN_DATA),
    .IN_LEN     (IN_LEN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .SER_DATA   (SER_DATA),
    .SER_ACTIVE (SER_ACTIVE),
    .CRC_BIT    (CRC_BIT),
    .CRC_VALID  (CRC_VALID),
    .OUT_CRC    (OUT_CRC),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .ERR        (ERR)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer a frame at a falling edge; expected bits go to the scoreboard.
  task automatic send_frame(input logic [31:0] d, input logic [1:0] len, output int nbits);
    chk1("in_ready_idle", IN_READY, 1'b1);
    IN_DATA  = d;
    IN_LEN   = len;
    IN_VALID = 1'b1;
    nbits = 8 * (int'(len) + 1);
    for (int i = 0; i < nbits; i++) q_bits.push_back(d[i]);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_DATA  = 32'hDEADBEEF;
    IN_LEN   = 2'd1;
  endtask

  // Pop and compare one serial bit per SHIFT cycle; optionally poke IN_VALID.
  task automatic shift_phase(input int n, input bit poke);
    logic eb;
    for (int i = 0; i < n; i++) begin
      if (poke) begin
        IN_VALID = 1'b1;
        IN_DATA  = $urandom;
        IN_LEN   = 2'd3;
      end
      chk1("ser_active_shift", SER_ACTIVE, 1'b1);
      chk1("in_ready_shift", IN_READY, 1'b0);
      eb = (q_bits.size() > 0) ? q_bits.pop_front() : 1'bx;
      chk1("ser_data", SER_DATA, eb);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    chk1("ser_active_end", SER_ACTIVE, 1'b0);
    chk1("ser_data_end", SER_DATA, 1'b0);
  endtask

  // Return CRC bits one at a time with 'gap' idle cycles between them.
  task automatic feed_crc(input logic [7:0] b, input int gap);
    q_crc.push_back(b);
    for (int i = 0; i < 8; i++) begin
      CRC_VALID = 1'b1;
      CRC_BIT   = b[i];
      @(negedge CLK);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          CRC_VALID = 1'b0;
          CRC_BIT   = 1'($urandom);
          chk1("err_gap", ERR, 1'b0);
          chk1("out_valid_gap", OUT_VALID, 1'b0);
          @(negedge CLK);
        end
      end
    end
    CRC_VALID = 1'b0;
  endtask

  // Wait (bounded) for OUT_VALID, compare against scoreboard, hold, drain.
  task automatic expect_result(input int hold);
    int k;
    logic [7:0] exp;
    k = 0;
    while (OUT_VALID !== 1'b1 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk1("out_valid", OUT_VALID, 1'b1);
    exp = (q_crc.size() > 0) ? q_crc.pop_front() : 8'hxx;
    chk8("out_crc", OUT_CRC, exp);
    chk1("err_result", ERR, 1'b0);
    for (int h = 0; h < hold; h++) begin
      OUT_READY = 1'b0;
      CRC_VALID = 1'b1;
      CRC_BIT   = ~exp[h % 8];
      @(negedge CLK);
      chk1("out_valid_hold", OUT_VALID, 1'b1);
      chk8("out_crc_hold", OUT_CRC, exp);
      chk1("in_ready_hold", IN_READY, 1'b0);
    end
    CRC_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk1("out_valid_drop", OUT_VALID, 1'b0);
    chk1("in_ready_back", IN_READY, 1'b1);
  endtask

  // Silence on CRC_VALID: ERR must rise exactly on the TIMEOUT-th cycle.
  task automatic expect_timeout();
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge CLK);
      chk1("err_timeout", ERR, i == TIMEOUT);
      chk1("out_valid_timeout", OUT_VALID, 1'b0);
    end
    chk1("in_ready_after_err", IN_READY, 1'b1);
    @(negedge CLK);
    chk1("err_one_pulse", ERR, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    logic eb;

    // Reset values
    repeat (2) @(negedge CLK);
    chk1("rst_in_ready", IN_READY, 1'b1);
    chk1("rst_ser_active", SER_ACTIVE, 1'b0);
    chk1("rst_ser_data", SER_DATA, 1'b0);
    chk8("rst_out_crc", OUT_CRC, 8'h00);
    chk1("rst_out_valid", OUT_VALID, 1'b0);
    chk1("rst_err", ERR, 1'b0);
    RST = 1'b1;

    // 1-byte frame 0xA5, CRC 0x3C held for 5 cycles
    send_frame(32'h000000A5, 2'd0, nb);
    shift_phase(nb, 1'b0);
    feed_crc(8'h3C, 0);
    expect_result(5);

    // 4-byte frame with IN_VALID poked during SHIFT
    send_frame(32'h12345678, 2'd3, nb);
    shift_phase(nb, 1'b1);
    feed_crc(8'h5A, 0);
    expect_result(0);

    // Pure timeout in CAPTURE
    send_frame(32'h0000BEEF, 2'd1, nb);
    shift_phase(nb, 1'b0);
    expect_timeout();

    // Three bits then silence
    send_frame(32'h000000C3, 2'd0, nb);
    shift_phase(nb, 1'b0);
    for (int i = 0; i < 3; i++) begin
      CRC_VALID = 1'b1;
      CRC_BIT   = 1'b1;
      @(negedge CLK);
    end
    CRC_VALID = 1'b0;
    expect_timeout();

    // Gapped CRC bits of 0x81 on a 3-byte frame
    send_frame(32'h00FF00FF, 2'd2, nb);
    shift_phase(nb, 1'b0);
    feed_crc(8'h81, 2);
    expect_result(1);

    // Reset during SHIFT cycle 5 of a 2-byte frame
    send_frame(32'h0000A5C3, 2'd1, nb);
    for (int i = 0; i < 4; i++) begin
      chk1("ser_active_pre_rst", SER_ACTIVE, 1'b1);
      eb = (q_bits.size() > 0) ? q_bits.pop_front() : 1'bx;
      chk1("ser_data_pre_rst", SER_DATA, eb);
      @(negedge CLK);
    end
    RST = 1'b0;
    #1;
    chk1("rst_mid_ser_active", SER_ACTIVE, 1'b0);
    chk1("rst_mid_ser_data", SER_DATA, 1'b0);
    chk1("rst_mid_in_ready", IN_READY, 1'b1);
    q_bits.delete();
    @(negedge CLK);
    chk1("rst_mid_out_valid", OUT_VALID, 1'b0);
    chk1("rst_mid_err", ERR, 1'b0);
    RST = 1'b1;
    send_frame(32'h00000096, 2'd0, nb);
    shift_phase(nb, 1'b0);
    feed_crc(8'hE7, 0);
    expect_result(0);

    chkn("scoreboard_empty", q_bits.size() + q_crc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
